ap_run_ctrl: RTL and testbench

AP_RUN_CTRL -- requirements
Module: ap_run_ctrl

---
 rtl/ap_run_ctrl.sv | 136 +++++++++++++
 tb/tb_ap_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_run_ctrl.sv
// ap_run_ctrl: sequences a batch of runs on an HLS core (ap_ctrl_hs) and times them.
// Build macro AP_RUN_CTRL_TIMEOUT_EN compiles in the WAIT-state timeout/abort.
module ap_run_ctrl #(
  parameter int          RUN_W   = 8,
  parameter int          CYC_W   = 32,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_start,
  input  logic [RUN_W-1:0] cmd_runs,
  output logic             busy,
  output logic             batch_done,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic [RUN_W-1:0] run_idx,
  output logic [CYC_W-1:0] cyc_last,
  output logic [CYC_W-1:0] cyc_total,
  output logic             tmo_err
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    START,
    WAIT,
    FIN
  } state_t;

  localparam logic [CYC_W-1:0] TMO_V = CYC_W'(TMO_CYC);

  state_t           state;
  logic [RUN_W-1:0] runs_q;
  logic [CYC_W-1:0] cnt;

  logic [CYC_W:0]   sum_w;
  logic [CYC_W-1:0] sum_sat;
  logic [CYC_W-1:0] cnt_nxt;
  logic             last_run;
  logic             run_end;
  logic             tmo_hit;

  assign sum_w   = {1'b0, cyc_total} + {1'b0, cnt};
  assign sum_sat = sum_w[CYC_W] ? '1 : sum_w[CYC_W-1:0];
  assign cnt_nxt = (&cnt) ? cnt : cnt + CYC_W'(1);

  assign last_run =
    ({1'b0, run_idx} + (RUN_W+1)'(1)) == {1'b0, runs_q};

  assign run_end =
    ((state == START) && ap_ready && ap_done) ||
    ((state == WAIT) && ap_done);

`ifdef AP_RUN_CTRL_TIMEOUT_EN
  // cnt already includes the current cycle, so the hit lands on cycle TMO_CYC
  assign tmo_hit = (state == WAIT) && !ap_done && (cnt >= TMO_V);
`else
  assign tmo_hit = 1'b0;
`endif

  // batch sequencer with registered outputs and run-cycle accounting
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      runs_q     <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      ap_start   <= 1'b0;
      run_idx    <= '0;
      cyc_last   <= '0;
      cyc_total  <= '0;
      tmo_err    <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_start) begin
            busy      <= 1'b1;
            runs_q    <= cmd_runs;
            run_idx   <= '0;
            cyc_total <= '0;
            tmo_err   <= 1'b0;
            if (cmd_runs == '0) begin
              state      <= FIN;
              batch_done <= 1'b1;
            end else begin
              state <= PRE;
            end
          end
        end
        PRE: begin
          if (ap_idle) begin
            state    <= START;
            ap_start <= 1'b1;
            cnt      <= CYC_W'(1);
          end
        end
        START, WAIT: begin
          if (run_end) begin
            ap_start  <= 1'b0;
            cyc_last  <= cnt;
            cyc_total <= sum_sat;
            if (last_run) begin
              state      <= FIN;
              batch_done <= 1'b1;
            end else begin
              state   <= PRE;
              run_idx <= run_idx + RUN_W'(1);
            end
          end else if (tmo_hit) begin
            tmo_err    <= 1'b1;
            cyc_last   <= TMO_V;
            cyc_total  <= sum_sat;
            state      <= FIN;
            batch_done <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
            if ((state == START) && ap_ready) begin
              ap_start <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_run_ctrl.sv
// tb_ap_run_ctrl: random + directed batches against a queue-based reference.
// HLS core modelled per run latency; scoreboard checked on each batch_done.
module tb_ap_run_ctrl;

  localparam int RW = 8;
`ifdef AP_RUN_CTRL_TIMEOUT_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam int TMO  = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic [RW-1:0] cmd_runs = '0;
  logic          busy;
  logic          batch_done;
  logic          ap_start;
  logic          ap_ready = 1'b0;
  logic          ap_done = 1'b0;
  logic          ap_idle = 1'b1;
  logic [RW-1:0] run_idx;
  logic [CW-1:0] cyc_last;
  logic [CW-1:0] cyc_total;
  logic          tmo_err;

  ap_run_ctrl #(
    .RUN_W(RW),
    .CYC_W(CW),
    .TMO_CYC(TMO)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .cmd_start(cmd_start),
    .cmd_runs(cmd_runs),
    .busy(busy),
    .batch_done(batch_done),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .run_idx(run_idx),
    .cyc_last(cyc_last),
    .cyc_total(cyc_total),
    .tmo_err(tmo_err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int hs;
    int idx;
    int last;
    int total;
    bit tmo;
    bit chk_total;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  bit   idle_rand = 1'b0;
  int   model_last = 0;
  bit   active = 1'b0;
  int   k = 0;
  int   cur_l = 0;
  int   prev_l = 0;
  int   last_start = -1;

  task automatic check(input string name, input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // HLS core model: latency per run from lat_q, 0 means never done
  always @(negedge ap_clk) begin
    cyc++;
    if (batch_done) lat_q.delete();
    if (!busy) begin
      active = 1'b0;
      last_start = -1;
    end else if (active) begin
      if (cur_l != 0 && k == cur_l) active = 1'b0;
      else k++;
    end
    if (!active && ap_start) begin
      active = 1'b1;
      k = 1;
      cur_l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      hs_cnt++;
      if (last_start >= 0)
        check("run_gap_min", longint'(cyc - last_start >= prev_l + 1), 1);
      last_start = cyc;
      prev_l = cur_l;
    end
    ap_ready = active && ap_start && (k == 1);
    ap_done  = active && (cur_l != 0) && (k == cur_l);
    ap_idle  = !active && (!idle_rand || ($urandom_range(3) != 0));
  end

  // scoreboard monitor: one expected record per accepted batch
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && batch_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_batch_done: got 1, expected 0");
      end else begin
        e = exp_q.pop_front();
        check("handshakes", hs_cnt, e.hs);
        check("run_idx", run_idx, e.idx);
        check("cyc_last", cyc_last, e.last);
        if (e.chk_total) check("cyc_total", cyc_total, e.total);
        check("tmo_err", tmo_err, e.tmo);
        check("busy_in_fin", busy, 1);
      end
      hs_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge ap_clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=1, expected 0");
    end
  endtask

  task automatic do_reset_mid();
    int n = 0;
    while (!(run_idx == 1 && ap_start) && n < 500) begin
      @(negedge ap_clk);
      n++;
    end
    check("reach_run2", run_idx, 1);
    repeat (3) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_run_idx", run_idx, 0);
    check("rst_cyc_last", cyc_last, 0);
    check("rst_cyc_total", cyc_total, 0);
    check("rst_tmo_err", tmo_err, 0);
    exp_q.delete();
    lat_q.delete();
    model_last = 0;
    hs_cnt = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic run_batch(input int runs, input int lat[$],
                           input bit tmo_case, input bit poke,
                           input bit rst_mid);
    exp_t e;
    int   sum = 0;
    wait_idle();
    e.hs = tmo_case ? 1 : runs;
    e.tmo = tmo_case;
    e.chk_total = !tmo_case;
    if (runs == 0) begin
      e.idx = 0;
      e.last = model_last;
      e.total = 0;
    end else if (tmo_case) begin
      e.idx = 0;
      e.last = TMO;
      e.total = 0;
    end else begin
      foreach (lat[i]) sum += lat[i];
      e.idx = runs - 1;
      e.last = lat[runs-1];
      e.total = (sum > CMAX) ? CMAX : sum;
    end
    model_last = e.last;
    foreach (lat[i]) lat_q.push_back(lat[i]);
    exp_q.push_back(e);
    cmd_runs = RW'(runs);
    cmd_start = 1'b1;
    @(negedge ap_clk);
    cmd_start = 1'b0;
    cmd_runs = RW'($urandom);
    check("busy_after_start", busy, 1);
    if (runs == 0) check("zero_runs_done", batch_done, 1);
    if (poke) begin
      repeat (4) @(negedge ap_clk);
      cmd_runs = RW'(2);
      cmd_start = 1'b1;
      @(negedge ap_clk);
      cmd_start = 1'b0;
    end
    if (rst_mid) do_reset_mid();
    else wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int lq[$];
    int r;
    repeat (3) @(negedge ap_clk);
    check("init_busy", busy, 0);
    check("init_ap_start", ap_start, 0);
    check("init_batch_done", batch_done, 0);
    check("init_run_idx", run_idx, 0);
    check("init_cyc_last", cyc_last, 0);
    check("init_cyc_total", cyc_total, 0);
    check("init_tmo_err", tmo_err, 0);
    ap_rst_n = 1'b1;

    lq = {5, 5, 5};
    run_batch(3, lq, 0, 0, 0);
    lq = {};
    run_batch(0, lq, 0, 0, 0);
    lq = {1, 1, 1};
    run_batch(3, lq, 0, 0, 0);
`ifdef AP_RUN_CTRL_TIMEOUT_EN
    lq = {0, 0, 0, 0};
    run_batch(4, lq, 1, 0, 0);
`endif
    lq = {6, 6, 6};
    run_batch(3, lq, 0, 0, 1);
    lq = {4, 4};
    run_batch(2, lq, 0, 0, 0);
    lq = (CW == 4) ? '{10, 10, 10} : '{10, 10, 10, 10};
    run_batch(lq.size(), lq, 0, 1, 0);

    idle_rand = 1'b1;
    for (int b = 0; b < 25; b++) begin
      r = $urandom_range(5);
      lq = {};
      for (int i = 0; i < r; i++) lq.push_back($urandom_range(8, 1));
      run_batch(r, lq, 0, 0, 0);
    end
    repeat (4) @(negedge ap_clk);
    check("pending_batches", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
